seq_detector_param: RTL
=======================

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 The block SHALL have parameter N, default 4, pattern length in bits (legal 2..16).
REQ-002 The block SHALL have parameter PAT_INIT, default 4'b0110 (N bits), pattern loaded at reset.
REQ-003 The block SHALL have parameter OVERLAP, default 1; 1 = overlapping matches allowed, 0 = history discarded after each match.
REQ-004 The block SHALL have parameter MOORE, default 1; 1 = registered Moore output, 0 = combinational Mealy output.
REQ-005 The block SHALL have parameter CNT_W, default 8, match-counter width.
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-007 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-008 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-009 The block SHALL have port en, input, 1, serial bit valid; x is sampled only when en=1.
REQ-010 The block SHALL have port x, input, 1, serial data bit.
REQ-011 The block SHALL have port load, input, 1, single-cycle strobe that loads a new pattern.
REQ-012 The block SHALL have port pattern, input, N, new pattern; captured when load=1.
REQ-013 The block SHALL have port cnt_clr, input, 1, synchronous clear of the match counter.
REQ-014 The block SHALL have port y, output, 1, match indication.
REQ-015 The block SHALL have port match_cnt, output, CNT_W, saturating count of matches.
REQ-016 The block SHALL have port cnt_sat, output, 1, high while match_cnt is at its maximum value.

Function
REQ-017 Bit order SHALL be: the first received bit compares against pat_reg[N-1] and the last received bit against pat_reg[0].
REQ-018 Each accepted bit SHALL shift into an N-bit history register: hist <= {hist[N-2:0], x}.
REQ-019 A fill counter SHALL count accepted bits since the last reset, load or non-overlap match, saturating at N.
REQ-020 A match SHALL occur on an accepted bit when (fill >= N-1) and {hist[N-2:0], x} == pat_reg; no match is possible before N bits have been accepted.
REQ-021 With MOORE=1, y SHALL be 1 for exactly the one cycle following each matching accepted bit, and 0 otherwise.
REQ-022 With MOORE=0, y SHALL equal en & match combinationally, in the same cycle as the matching bit.
REQ-023 With OVERLAP=1, history and fill SHALL be kept on a match, so that subsequent bits can complete an overlapping match.
REQ-024 With OVERLAP=0, fill SHALL be set to 0 on a match; the matching bit is not reused.
REQ-025 With en=0, hist, fill and match_cnt SHALL hold; with MOORE=1, y SHALL drop to 0 in the next cycle.
REQ-026 load=1 SHALL capture pattern into pat_reg and clear hist, fill and the registered y; a bit presented with en=1 in the same cycle SHALL be discarded (load wins).
REQ-027 match_cnt SHALL increment by 1 on each match and saturate at 2^CNT_W-1 without wrapping; cnt_sat = (match_cnt == all ones).
REQ-028 cnt_clr=1 SHALL set match_cnt to 0; if a match occurs in the same cycle, the clear wins and the count becomes 0.
REQ-029 load SHALL NOT affect match_cnt.

Reset
REQ-030 When rst=0, the block SHALL asynchronously set pat_reg=PAT_INIT, hist=0, fill=0, match_cnt=0, and y=0 (MOORE=1), and cnt_sat=0.
REQ-031 Reset asserted mid-stream SHALL discard all partial history; after release, a full N accepted bits SHALL be required before any match.
REQ-032 With MOORE=0, y SHALL be 0 while rst=0.

Verification
REQ-033 Defaults (N=4, 0110, OVERLAP=1, MOORE=1), stream 0,1,1,0,1,1,0 with en=1 -> y pulses the cycle after bit 4 and after bit 7; match_cnt=2.
REQ-034 Same stream with OVERLAP=0 -> a single y pulse after bit 4; match_cnt=1.
REQ-035 MOORE=0, stream 0,1,1,0 -> y=1 combinationally during bit 4; en=0 idle cycles inserted between bits 2 and 3 -> same single match, y=0 during idle cycles.
REQ-036 Load pattern 4'b1010 after bits 0,1 of a stream, then send 1,0,1,0 -> match only after the fourth post-load bit; a bit sent in the same cycle as load is ignored.
REQ-037 CNT_W=2, five matches -> match_cnt=3 with cnt_sat=1 after the third match; cnt_clr coincident with a match -> match_cnt=0.
REQ-038 rst=0 pulse after bits 0,1,1 of 0110 -> no match on the following bit 0; pat_reg returns to 0110, and all outputs are 0 immediately.

Source files
------------

// File: rtl/seq_detector_param_if.sv
// Serial pattern detector bus: bit stream, pattern load and counter control
// in, match pulse and saturating match counter out. The detector itself is
// the slave; whoever feeds the bit stream is the master.
interface seq_detector_param_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
);

  // Serial bit stream and its qualifier
  logic             en;
  logic             x;

  // Runtime pattern replacement
  logic             load;
  logic [N-1:0]     pattern;

  // Match counter control
  logic             cnt_clr;

  // Detector results
  logic             y;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  modport master (
    output en,
    output x,
    output load,
    output pattern,
    output cnt_clr,
    input  y,
    input  match_cnt,
    input  cnt_sat
  );

  modport slave (
    input  en,
    input  x,
    input  load,
    input  pattern,
    input  cnt_clr,
    output y,
    output match_cnt,
    output cnt_sat
  );

endinterface

// File: rtl/seq_detector_param.sv
// Parameterised serial sequence detector.
// Bits arrive MSB-of-pattern first; each accepted bit is shifted into an
// N-bit history and compared, together with the history, against a
// runtime-loadable pattern. Matches can overlap or restart the search,
// the match indication is either a registered Moore pulse or a
// combinational Mealy strobe, and matches are tallied in a saturating
// counter that can be cleared synchronously.
module seq_detector_param #(
  parameter int             N        = 4,
  parameter logic [N-1:0]   PAT_INIT = N'(4'b0110),
  parameter int             OVERLAP  = 1,
  parameter int             MOORE    = 1,
  parameter int             CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_detector_param_if.slave  bus
);

  // Fill counts 0..N, so it needs enough bits to hold N itself.
  localparam int               FILL_W    = $clog2(N + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);
  // A match needs N-1 earlier bits in the history plus the current one.
  localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(N - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end
    return v + 1'b1;
  endfunction

  // Fill counter step that stops once a full pattern's worth is held.
  function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] f);
    if (f == FILL_FULL) begin
      return f;
    end
    return f + 1'b1;
  endfunction

  logic [N-1:0]      pat_reg;
  logic [N-1:0]      hist;
  logic [FILL_W-1:0] fill;
  logic [CNT_W-1:0]  match_cnt;
  logic              y_reg;

  logic              accept;
  logic [N-1:0]      hist_nxt;
  logic              armed;
  logic              match;
  logic              y_mealy;

  // A load in the same cycle as a valid bit discards that bit.
  assign accept   = bus.en & ~bus.load;

  // History as it would look with the current bit shifted in; the bit that
  // falls off the top is the one that no longer takes part in a compare.
  assign hist_nxt = (hist << 1) | {{(N-1){1'b0}}, bus.x};

  assign armed    = (fill >= FILL_ARM);
  assign match    = accept & armed & (hist_nxt == pat_reg);

  // Mealy strobe is forced low while reset is asserted.
  assign y_mealy  = rst & bus.en & match;

  assign bus.y         = (MOORE != 0) ? y_reg : y_mealy;
  assign bus.match_cnt = match_cnt;
  assign bus.cnt_sat   = (match_cnt == CNT_MAX);

  // Pattern register: reset to the build-time pattern, replaced on load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_reg <= PAT_INIT;
    end else if (bus.load) begin
      pat_reg <= bus.pattern;
    end
  end

  // Bit history: cleared on load, shifts only on accepted bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= '0;
    end else if (bus.load) begin
      hist <= '0;
    end else if (accept) begin
      hist <= hist_nxt;
    end
  end

  // Fill counter: how many valid history bits back a compare. Without
  // overlap a match empties it so the matching bit is never reused.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill <= '0;
    end else if (bus.load) begin
      fill <= '0;
    end else if (accept) begin
      if (match && (OVERLAP == 0)) begin
        fill <= '0;
      end else begin
        fill <= fill_inc(fill);
      end
    end
  end

  // Registered match pulse: high for the one cycle after a matching bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_reg <= 1'b0;
    end else if (bus.load) begin
      y_reg <= 1'b0;
    end else begin
      y_reg <= match;
    end
  end

  // Saturating match counter; a clear overrides a coincident match and a
  // pattern load leaves the tally untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_cnt <= '0;
    end else if (bus.cnt_clr) begin
      match_cnt <= '0;
    end else if (match) begin
      match_cnt <= sat_inc(match_cnt);
    end
  end

endmodule
